sha256_msg_sched: RTL

//  Message scheduler and padder in front of the SHA-256 compression core.

---
 rtl/sha256_msg_sched.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
//   Message scheduler and padder in front of a SHA-256 compression core.
//   Takes a big-endian 32-bit word stream over valid/ready, appends the
//   0x80 marker, zero fill and the 64-bit message bit length, and hands the
//   padded message to the core as 16-word blocks. It waits for core_done_i
//   after every block before producing the next one.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   msg_valid_i/ready_o word handshake; ready only while accepting data
//   msg_data_i          message word, byte 0 in [31:24]
//   msg_last_i          final message word (sampled on a transfer only)
//   msg_last_bytes_i    valid bytes in the final word (1..3, 0 means 4)
//   core_dat_vaild_o    registered word-valid to the core
//   core_dat_o          registered word to the core
//   core_first_o        high with the very first word of the message
//   core_done_i         core finished the current block (pulse)
//   busy_o              message in progress
//   done_o              pulse: final block hashed, digest valid
module sha256_msg_sched #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid_i,
  output logic        msg_ready_o,
  input  logic [31:0] msg_data_i,
  input  logic        msg_last_i,
  input  logic [1:0]  msg_last_bytes_i,
  output logic        core_dat_vaild_o,
  output logic [31:0] core_dat_o,
  output logic        core_first_o,
  input  logic        core_done_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_LEN, S_WAIT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  state_e             nxt_q, nxt_d;      // where WAIT resumes after core_done_i
  logic [3:0]         wcnt_q, wcnt_d;    // words emitted in the current block
  logic [LEN_W-1:0]   bcnt_q, bcnt_d;    // message bytes accepted so far
  logic               owed_q, owed_d;    // 0x80 marker still to be emitted
  logic               first_q, first_d;  // next emitted word is word 0 of block 0
  logic               vld_q, vld_d;
  logic [31:0]        dat_q, dat_d;
  logic               fo_q, fo_d;
  logic               done_q, done_d;

  logic               emit;
  logic [31:0]        word;
  logic [3:0]         wnext;
  logic [63:0]        len64;

  // Final word: keep the valid bytes, put the marker right after them and
  // clear whatever the source left in the unused bytes.
  function automatic logic [31:0] mask_last(input logic [31:0] d, input logic [1:0] nb);
    case (nb)
      2'd1:    mask_last = {d[31:24], 8'h80, 16'h0000};
      2'd2:    mask_last = {d[31:16], 8'h80, 8'h00};
      2'd3:    mask_last = {d[31:8], 8'h80};
      default: mask_last = d;
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] b, input logic [2:0] a);
    logic [LEN_W:0] s;
    s = {1'b0, b} + (LEN_W+1)'(a);
    sat_add = s[LEN_W] ? {LEN_W{1'b1}} : s[LEN_W-1:0];
  endfunction

  assign wnext = wcnt_q + 4'd1;
  assign len64 = 64'(bcnt_q) << 3;

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    owed_d  = owed_q;
    first_d = first_q;
    vld_d   = 1'b0;
    dat_d   = dat_q;
    fo_d    = 1'b0;
    done_d  = 1'b0;
    emit    = 1'b0;
    word    = 32'h0;

    case (state_q)
      S_IDLE: begin
        wcnt_d  = 4'd0;
        bcnt_d  = '0;
        owed_d  = 1'b0;
        first_d = 1'b1;
        if (msg_valid_i) state_d = S_FILL;
      end
      S_FILL: begin
        if (msg_valid_i) begin
          emit = 1'b1;
          if (msg_last_i) begin
            word   = mask_last(msg_data_i, msg_last_bytes_i);
            bcnt_d = sat_add(bcnt_q, (msg_last_bytes_i == 2'd0) ? 3'd4 : {1'b0, msg_last_bytes_i});
            owed_d = (msg_last_bytes_i == 2'd0);
            if (wnext == 4'd0) begin
              state_d = S_WAIT;
              nxt_d   = S_PAD;
            end else if (wnext == 4'd14 && msg_last_bytes_i != 2'd0) begin
              state_d = S_LEN;   // marker already placed, length fits here
            end else begin
              state_d = S_PAD;
            end
          end else begin
            word   = msg_data_i;
            bcnt_d = sat_add(bcnt_q, 3'd4);
            if (wnext == 4'd0) begin
              state_d = S_WAIT;
              nxt_d   = S_FILL;
            end
          end
        end
      end
      S_PAD: begin
        emit   = 1'b1;
        word   = owed_q ? 32'h8000_0000 : 32'h0;
        owed_d = 1'b0;
        if (wnext == 4'd0) begin
          // marker landed too late for the length: length-only block follows
          state_d = S_WAIT;
          nxt_d   = S_PAD;
        end else if (wnext == 4'd14) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        emit = 1'b1;
        word = wcnt_q[0] ? len64[31:0] : len64[63:32];
        if (wcnt_q == 4'd15) begin
          state_d = S_WAIT;
          nxt_d   = S_DONE;
        end
      end
      S_WAIT: begin
        if (core_done_i) begin
          state_d = nxt_q;
          done_d  = (nxt_q == S_DONE);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      vld_d   = 1'b1;
      dat_d   = word;
      fo_d    = first_q;
      first_d = 1'b0;
      wcnt_d  = wnext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nxt_q   <= S_IDLE;
      wcnt_q  <= 4'd0;
      bcnt_q  <= '0;
      owed_q  <= 1'b0;
      first_q <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= 32'h0;
      fo_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      owed_q  <= owed_d;
      first_q <= first_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      fo_q    <= fo_d;
      done_q  <= done_d;
    end
  end

  assign msg_ready_o      = (state_q == S_FILL);
  assign busy_o           = (state_q != S_IDLE);
  assign core_dat_vaild_o = vld_q;
  assign core_dat_o       = dat_q;
  assign core_first_o     = fo_q;
  assign done_o           = done_q;

endmodule
